regfile_2r1w: RTL and testbench

- Parametrised successor to the 8x16 single-read register file.
- Generic width and depth; two independent registered read ports; one write port with write-to-read bypass.
- Sequential bulk-clear engine with a busy handshake.
- Sits between the RISC decode stage, which drives the read addresses, and writeback, which drives the write port.

---
 rtl/regfile_2r1w.sv | 177 +++++++++++++++++
 tb/tb_regfile_2r1w.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with two registered read ports,
// one write port with write-to-read bypass, and a sequential bulk-clear
// engine that reports progress on clear_busy.
//
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero,
// writes to index 0 are discarded and the clear engine starts at index 1.
//
// Handshake: clear_busy is a plain registered status flag. While it is high
// the write port is owned by the clear engine and any write_en is dropped,
// so the writeback stage must stall on clear_busy. clear_req is only
// sampled while clear_busy is low.

module regfile_2r1w #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    write_addr,
    input  logic             write_en,
    input  logic [AW-1:0]    read_addr_a,
    input  logic [AW-1:0]    read_addr_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    input  logic             clear_req,
    output logic             clear_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
`ifdef REGFILE_ZERO_REG_EN
    localparam logic [AW-1:0] CLR_FIRST = AW'(1);
`else
    localparam logic [AW-1:0] CLR_FIRST = AW'(0);
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Effective write port: the clear engine owns it in CLEAR, otherwise the
    // external port drives it when the address is in range.
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Select the source of this edge's register write.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = write_addr;
        wr_data = data_in;
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (write_en && ({1'b0, write_addr} < DEPTH_EXT)) begin
            wr_en = 1'b1;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (wr_addr == '0) begin
            wr_en = 1'b0;
        end
`endif
    end

    // Port A next value: out-of-range reads zero, same-edge write bypasses.
    always_comb begin
        rd_a_d = '0;
        if ({1'b0, read_addr_a} < DEPTH_EXT) begin
            if (wr_en && (wr_addr == read_addr_a)) begin
                rd_a_d = wr_data;
            end else begin
                rd_a_d = mem_q[read_addr_a];
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (read_addr_a == '0) begin
            rd_a_d = '0;
        end
`endif
    end

    // Port B next value: same rules as port A, fully independent.
    always_comb begin
        rd_b_d = '0;
        if ({1'b0, read_addr_b} < DEPTH_EXT) begin
            if (wr_en && (wr_addr == read_addr_b)) begin
                rd_b_d = wr_data;
            end else begin
                rd_b_d = mem_q[read_addr_b];
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (read_addr_b == '0) begin
            rd_b_d = '0;
        end
`endif
    end

    // Clear FSM next state: walk the counter from CLR_FIRST up to DEPTH-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CLR_FIRST;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Clear FSM state, counter and busy flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read data for both ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign data_out_a = rd_a_q;
    assign data_out_b = rd_b_q;
    assign clear_busy = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench for regfile_2r1w with a scoreboard.
// Build with REGFILE_ZERO_REG_EN defined to exercise the zero-register
// variant at DEPTH=6.

module tb_regfile_2r1w;

    localparam int WIDTH = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam int DEPTH = 6;
`else
    localparam int DEPTH = 8;
`endif
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic [AW-1:0]    write_addr = '0;
    logic             write_en = 1'b0;
    logic [AW-1:0]    read_addr_a = '0;
    logic [AW-1:0]    read_addr_b = '0;
    logic [WIDTH-1:0] data_out_a;
    logic [WIDTH-1:0] data_out_b;
    logic             clear_req = 1'b0;
    logic             clear_busy;

    always #5 clk = ~clk;

    regfile_2r1w #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_addr (write_addr),
        .write_en   (write_en),
        .read_addr_a(read_addr_a),
        .read_addr_b(read_addr_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    // ---------------- scoreboard ----------------
    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_a_q[$];
    logic [WIDTH-1:0] exp_b_q[$];
    string            tag_q[$];
    logic             chk_v = 1'b0;
    logic             chk_v_q = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A read issued at one negedge appears after the following posedge.
    always @(posedge clk) chk_v_q <= chk_v;

    // Monitor: pop and compare whenever the read pipeline presents data.
    always @(negedge clk) begin
        if (chk_v_q) begin
            if (exp_a_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry");
            end else begin
                string t;
                t = tag_q.pop_front();
                check({t, "_a"}, data_out_a, exp_a_q.pop_front());
                check({t, "_b"}, data_out_b, exp_b_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic we, input logic [AW-1:0] wa,
                       input logic [WIDTH-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic chk, input logic [WIDTH-1:0] ea,
                       input logic [WIDTH-1:0] eb, input logic clr,
                       input string tag);
        @(negedge clk);
        write_en    = we;
        write_addr  = wa;
        data_in     = wd;
        read_addr_a = ra;
        read_addr_b = rb;
        clear_req   = clr;
        chk_v       = chk;
        if (chk) begin
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
            tag_q.push_back(tag);
        end
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                      input string tag);
        cyc(1'b0, '0, '0, ra, rb, 1'b1, ea, eb, 1'b0, tag);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd);
        cyc(1'b1, wa, wd, '0, '0, 1'b0, '0, '0, 1'b0, "");
    endtask

    task automatic nop();
        cyc(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, "");
    endtask

    // Pulse clear_req for one cycle and count the busy cycles that follow.
    task automatic clear_and_count(input int exp_cycles);
        int n;
        n = 0;
        cyc(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b1, "");
        for (int i = 0; i < 20; i++) begin
            nop();
            if (clear_busy) n++;
        end
        check("busy_cycles", WIDTH'(n), WIDTH'(exp_cycles));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("reset_out_a", data_out_a, '0);
        check("reset_out_b", data_out_b, '0);
        check("reset_busy", WIDTH'(clear_busy), '0);
        @(negedge clk);
        reset = 1'b0;

        rd(3, 5, '0, '0, "reset_read");
`ifndef REGFILE_ZERO_REG_EN
        rd(3, 7, '0, '0, "reset_read37");

        // write then dual read
        wr(5, 16'hBEEF);
        rd(5, 5, 16'hBEEF, 16'hBEEF, "dual_read");

        // bypass
        wr(2, 16'h1111);
        cyc(1'b1, 2, 16'h2222, 2, 5, 1'b1, 16'h2222, 16'hBEEF, 1'b0, "bypass");
        rd(2, 2, 16'h2222, 16'h2222, "after_bypass");

        // fill r0..r7, reading each through the bypass
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, AW'(i), WIDTH'(16'hA0 + i), AW'(i), AW'(i), 1'b1,
                WIDTH'(16'hA0 + i), WIDTH'(16'hA0 + i), 1'b0, "fill");
        end
        rd(6, 1, 16'hA6, 16'hA1, "fill_readback");

        // clear pulse with a same-edge write to r3 (accepted)
        cyc(1'b1, 3, 16'h3333, 3, 0, 1'b1, 16'h3333, 16'hA0, 1'b1, "clr_edge");
        check("busy_before_clear", WIDTH'(clear_busy), '0);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                cyc(1'b0, 0, 0, 0, 1, 1'b1, '0, 16'hA1, 1'b0, "clear_k0");
            end else if (k == 1) begin
                // write during busy is dropped
                cyc(1'b1, 7, 16'h7777, 1, 3, 1'b1, '0, 16'h3333, 1'b0, "clear_k1");
            end else begin
                cyc(1'b0, 0, 0, AW'(k), 7, 1'b1, '0,
                    (k == 7) ? WIDTH'(0) : WIDTH'(16'hA7), 1'b0, "clear_kn");
            end
            check("busy_during_clear", WIDTH'(clear_busy), WIDTH'(1));
        end
        for (int i = 0; i < 8; i++) begin
            rd(AW'(i), AW'(7 - i), '0, '0, "post_clear");
            if (i == 0) check("busy_after_clear", WIDTH'(clear_busy), '0);
        end

        // async reset in the 4th busy cycle
        wr(4, 16'h4444);
        wr(6, 16'h6666);
        cyc(1'b0, 0, 0, 6, 4, 1'b1, 16'h6666, 16'h4444, 1'b1, "mid_clr_edge");
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 0, 0, 6, 4, 1'b1, 16'h6666, 16'h4444, 1'b0, "mid_clr");
            check("busy_mid_clear", WIDTH'(clear_busy), WIDTH'(1));
        end
        cyc(1'b0, 0, 0, 6, 4, 1'b0, '0, '0, 1'b0, "");
        check("busy_4th_cycle", WIDTH'(clear_busy), WIDTH'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", WIDTH'(clear_busy), '0);
        check("async_rst_out_a", data_out_a, '0);
        check("async_rst_out_b", data_out_b, '0);
        #1;
        reset = 1'b0;
        rd(6, 4, '0, '0, "post_async_rst");
        check("busy_post_rst", WIDTH'(clear_busy), '0);
        wr(1, 16'h0101);
        rd(1, 6, 16'h0101, '0, "idle_after_rst");
        clear_and_count(8);
        rd(1, 1, '0, '0, "post_second_clear");
`else
        // zero register: write to r0 discarded, also through bypass
        wr(1, 16'h1234);
        cyc(1'b1, 0, 16'h5555, 0, 1, 1'b1, '0, 16'h1234, 1'b0, "r0_bypass");
        rd(0, 1, '0, 16'h1234, "r0_read");

        // out-of-range write dropped, out-of-range read returns zero
        cyc(1'b1, 7, 16'h7777, 7, 7, 1'b1, '0, '0, 1'b0, "oob_bypass");
        rd(7, 6, '0, '0, "oob_read");
        rd(1, 0, 16'h1234, '0, "no_alias");

        // fill r1..r5 then clear
        for (int i = 1; i < 6; i++) wr(AW'(i), WIDTH'(16'hA0 + i));
        rd(5, 2, 16'hA5, 16'hA2, "fill_readback");
        clear_and_count(5);
        for (int i = 0; i < 6; i++) rd(AW'(i), AW'(5 - i), '0, '0, "post_clear");
`endif
        nop();
        nop();
        nop();
        if (exp_a_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_a_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
